adder_result_checker: RTL and testbench

- Hardware receive/check end of the adder stimulus interface: consumes operand pairs plus the sum/cout produced by a carry-select adder (CSelA8/16/32/64) and compares them against a golden a+b.
- Counts vectors and mismatches and captures the first failing vector.
- Turns open-loop $monitor-style observation into a self-checking, synthesizable checker usable in benches and on-chip BIST.

---
 rtl/adder_result_checker.sv | 182 ++++++++++++++++++
 tb/tb_adder_result_checker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// adder_result_checker: self-checking receiver for a combinational adder under test.
// It compares each accepted {cout,sum} against a golden a+b and counts vectors and mismatches.
// It also records the first failing vector.
// Latency: counters and captures update on the accepting edge and are visible the next cycle.
// Throughput: up to 1 vector/clk. in_ready is high only in RUN, so a producer stalls
// (holds in_valid) outside a run. Idle gaps in RUN are harmless.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset (priority over all inputs)
//   start           one-cycle run start, honoured in IDLE or DONE; num_vectors sampled with it
//   in_valid/in_ready  vector handshake; a, b, sum, cout belong to the same cycle
//   busy, done, pass   run status; pass = done with no mismatches
//   err_count, vec_count  mismatching / accepted vectors in this run (err_count saturates)
//   first_err_idx/sum/cout  vec_count index and DUT outputs of the first mismatch
//   signature       32-bit MISR over accepted {cout,sum}; present only with ADDER_CHK_MISR_EN
//
// Build option: define ADDER_CHK_MISR_EN to add the signature output and its MISR.
module adder_result_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_sum,
  output logic             first_err_cout
`ifdef ADDER_CHK_MISR_EN
  ,
  output logic [31:0]      signature
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_vec_count;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_first_err_idx;
  logic [WIDTH-1:0] r_first_err_sum;
  logic             r_first_err_cout;

  logic [WIDTH:0]   w_exp;
  logic             w_mismatch;
  logic             w_accept;
  logic             w_start_ok;
  logic [CNT_W-1:0] w_vec_inc;
  logic             w_last;

  // Golden result: WIDTH+1-bit sum with carry-in 0, compared as {cout,sum}.
  assign w_exp      = {1'b0, a} + {1'b0, b};
  assign w_mismatch = ({cout, sum} != w_exp);
  assign w_accept   = in_valid && (r_state == S_RUN);
  assign w_start_ok = start && (r_state != S_RUN);
  assign w_vec_inc  = r_vec_count + CNT_W'(1);
  assign w_last     = (w_vec_inc == r_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          // An empty run completes immediately and passes.
          w_next_state = (num_vectors == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept && w_last) begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target         <= '0;
      r_vec_count      <= '0;
      r_err_count      <= '0;
      r_first_err_idx  <= '0;
      r_first_err_sum  <= '0;
      r_first_err_cout <= 1'b0;
    end else if (w_start_ok) begin
      r_target         <= num_vectors;
      r_vec_count      <= '0;
      r_err_count      <= '0;
      r_first_err_idx  <= '0;
      r_first_err_sum  <= '0;
      r_first_err_cout <= 1'b0;
    end else if (w_accept) begin
      r_vec_count <= w_vec_inc;
      if (w_mismatch) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
        // err_count saturates and never returns to zero within a run,
        // so zero here identifies the first mismatch.
        if (r_err_count == '0) begin
          r_first_err_idx  <= r_vec_count;
          r_first_err_sum  <= sum;
          r_first_err_cout <= cout;
        end
      end
    end
  end

  assign pass           = done && (r_err_count == '0);
  assign err_count      = r_err_count;
  assign vec_count      = r_vec_count;
  assign first_err_idx  = r_first_err_idx;
  assign first_err_sum  = r_first_err_sum;
  assign first_err_cout = r_first_err_cout;

`ifdef ADDER_CHK_MISR_EN
  // Number of 32-bit chunks needed to cover the WIDTH+1-bit {cout,sum}.
  localparam int          NCH  = (WIDTH + 32) / 32;
  // x^32 + x^22 + x^2 + x + 1, top term implicit.
  localparam logic [31:0] POLY = 32'h0040_0007;

  logic [NCH*32-1:0] w_pad;
  logic [31:0]       w_fold;
  logic [31:0]       r_sig;

  assign w_pad = {{(NCH*32-WIDTH-1){1'b0}}, cout, sum};

  always_comb begin
    w_fold = '0;
    for (int i = 0; i < NCH; i++) begin
      w_fold = w_fold ^ w_pad[i*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= 32'hFFFF_FFFF;
    end else if (w_start_ok) begin
      r_sig <= 32'hFFFF_FFFF;
    end else if (w_accept) begin
      r_sig <= {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ w_fold;
    end
  end

  assign signature = r_sig;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: WIDTH=8 instance driven from a vector table,
// WIDTH=64 instance driven with random vectors against a scoreboard model.
`timescale 1ns/1ps
module tb_adder_result_checker;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // ---------------- WIDTH=8 instance ----------------
  logic          s8_start, s8_valid, s8_cout;
  logic [CW-1:0] s8_nv;
  logic [7:0]    s8_a, s8_b, s8_sum;
  logic          o8_rdy, o8_busy, o8_done, o8_pass, o8_fcout;
  logic [CW-1:0] o8_err, o8_vec, o8_fidx;
  logic [7:0]    o8_fsum;
  // ---------------- WIDTH=64 instance ----------------
  logic          s64_start, s64_valid, s64_cout;
  logic [CW-1:0] s64_nv;
  logic [63:0]   s64_a, s64_b, s64_sum;
  logic          o64_rdy, o64_busy, o64_done, o64_pass, o64_fcout;
  logic [CW-1:0] o64_err, o64_vec, o64_fidx;
  logic [63:0]   o64_fsum;
`ifdef ADDER_CHK_MISR_EN
  logic [31:0]   o8_sig, o64_sig;
`endif

  adder_result_checker #(.WIDTH(8), .CNT_W(CW)) u8 (
    .clk(clk), .rst(rst), .start(s8_start), .num_vectors(s8_nv),
    .in_valid(s8_valid), .in_ready(o8_rdy), .a(s8_a), .b(s8_b),
    .sum(s8_sum), .cout(s8_cout), .busy(o8_busy), .done(o8_done),
    .pass(o8_pass), .err_count(o8_err), .vec_count(o8_vec),
    .first_err_idx(o8_fidx), .first_err_sum(o8_fsum), .first_err_cout(o8_fcout)
`ifdef ADDER_CHK_MISR_EN
    , .signature(o8_sig)
`endif
  );

  adder_result_checker #(.WIDTH(64), .CNT_W(CW)) u64 (
    .clk(clk), .rst(rst), .start(s64_start), .num_vectors(s64_nv),
    .in_valid(s64_valid), .in_ready(o64_rdy), .a(s64_a), .b(s64_b),
    .sum(s64_sum), .cout(s64_cout), .busy(o64_busy), .done(o64_done),
    .pass(o64_pass), .err_count(o64_err), .vec_count(o64_vec),
    .first_err_idx(o64_fidx), .first_err_sum(o64_fsum), .first_err_cout(o64_fcout)
`ifdef ADDER_CHK_MISR_EN
    , .signature(o64_sig)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model for the WIDTH=64 instance ----------------
  int          m_nv, m_vec, m_err, m_fidx;
  logic [63:0] m_fsum;
  logic        m_fcout;
  logic [31:0] m_sig;
  logic [63:0] qa[$], qb[$], qs[$];
  logic        qc[$];

  // Signature step: multiply by x modulo P(x), then add the folded data word.
  function automatic logic [31:0] misr_next(input logic [31:0] st, input logic [64:0] d);
    logic [32:0] x;
    logic [31:0] fold;
    fold = d[31:0] ^ d[63:32] ^ {31'b0, d[64]};
    x = {st, 1'b0};
    if (x[32]) x = x ^ 33'h1_0040_0007;
    return x[31:0] ^ fold;
  endfunction

  task automatic model_accept(input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] s, input logic c);
    logic [64:0] golden;
    golden = {1'b0, a} + {1'b0, b};
    if ({c, s} !== golden) begin
      if (m_err == 0) begin
        m_fidx  = m_vec;
        m_fsum  = s;
        m_fcout = c;
      end
      m_err++;
    end
    m_vec++;
    m_sig = misr_next(m_sig, {c, s});
  endtask

  task automatic drv64(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] s, input logic c);
    s64_valid = v; s64_a = a; s64_b = b; s64_sum = s; s64_cout = c;
  endtask

  task automatic start64(input int nv);
    @(negedge clk);
    s64_start = 1'b1;
    s64_nv    = CW'(nv);
    m_nv = nv; m_vec = 0; m_err = 0; m_fidx = 0; m_fsum = '0; m_fcout = 1'b0;
    m_sig = 32'hFFFF_FFFF;
    @(negedge clk);
    s64_start = 1'b0;
  endtask

  task automatic check64_state(input string tag);
    chk({tag, "_rdy"},  64'(o64_rdy),  64'(m_vec < m_nv));
    chk({tag, "_busy"}, 64'(o64_busy), 64'(m_vec < m_nv));
    chk({tag, "_done"}, 64'(o64_done), 64'(m_vec == m_nv));
    chk({tag, "_vec"},  64'(o64_vec),  64'(m_vec));
    chk({tag, "_err"},  64'(o64_err),  64'(m_err));
  endtask

  task automatic final64(input string tag);
    chk({tag, "_pass"},  64'(o64_pass),  64'(m_err == 0));
    chk({tag, "_fidx"},  64'(o64_fidx),  64'(m_fidx));
    chk({tag, "_fsum"},  o64_fsum,       m_fsum);
    chk({tag, "_fcout"}, 64'(o64_fcout), 64'(m_fcout));
`ifdef ADDER_CHK_MISR_EN
    chk({tag, "_sig"},   64'(o64_sig),   64'(m_sig));
`endif
  endtask

  // One full run. replay reuses the stored vector queue; pat/pat_len force the
  // in_valid sequence; mid_start pulses start (with a different count) during RUN.
  task automatic run64(input string tag, input int nv, input int err_pct, input bit replay,
                       input logic [15:0] pat, input int pat_len, input bit mid_start);
    int cyc = 0;
    int k = 0;
    int bitpos;
    logic go;
    logic [63:0] a, b, s;
    logic c;
    logic [64:0] t;
    if (!replay) begin
      qa.delete(); qb.delete(); qs.delete(); qc.delete();
    end
    start64(nv);
    forever begin
      check64_state(tag);
      if (m_vec == m_nv) break;
      if (cyc > 4000) begin
        checks++; errors++;
        $display("FAIL %s_timeout: vec_count 0x%0h never reached 0x%0h", tag, o64_vec, m_nv);
        break;
      end
      if (pat_len > 0) go = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else             go = ($urandom_range(0, 3) != 0);
      if (go) begin
        if (replay) begin
          a = qa[k]; b = qb[k]; s = qs[k]; c = qc[k];
        end else begin
          a = {$urandom, $urandom};
          b = {$urandom, $urandom};
          t = {1'b0, a} + {1'b0, b};
          if ($urandom_range(0, 99) < err_pct) begin
            bitpos = $urandom_range(0, 64);
            t[bitpos] = ~t[bitpos];
          end
          s = t[63:0]; c = t[64];
          qa.push_back(a); qb.push_back(b); qs.push_back(s); qc.push_back(c);
        end
        k++;
        drv64(1'b1, a, b, s, c);
        model_accept(a, b, s, c);
      end else begin
        drv64(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      end
      if (mid_start && cyc == 1) begin
        s64_start = 1'b1;
        s64_nv    = CW'(nv + 7);
      end
      @(negedge clk);
      s64_start = 1'b0;
      cyc++;
    end
    drv64(1'b0, '0, '0, '0, 1'b0);
    final64(tag);
  endtask

  // ---------------- WIDTH=8 vector table ----------------
  typedef struct {
    bit          do_start;
    logic [CW-1:0] nv;
    logic [7:0]  a, b, sum;
    logic        cout;
    int          exp_vec, exp_err;
    bit          exp_done, exp_pass;
  } vec8_t;
  vec8_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 16'd3, 8'hA0, 8'hA0, 8'h40, 1'b1, 1, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'd0, 8'h58, 8'hF4, 8'h4C, 1'b1, 2, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 16'd0, 8'h3D, 8'h0F, 8'h4C, 1'b0, 3, 0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 16'd2, 8'h12, 8'h34, 8'h46, 1'b0, 1, 0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 16'd0, 8'hCA, 8'hC8, 8'h93, 1'b1, 2, 1, 1'b1, 1'b0};

    rst = 1'b1;
    s8_start = 1'b0; s8_nv = '0; s8_valid = 1'b0; s8_a = '0; s8_b = '0; s8_sum = '0; s8_cout = 1'b0;
    s64_start = 1'b0; s64_nv = '0; drv64(1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    chk("rst8_rdy",  64'(o8_rdy),  0);
    chk("rst8_done", 64'(o8_done), 0);
    chk("rst8_pass", 64'(o8_pass), 0);
    chk("rst8_vec",  64'(o8_vec),  0);
    chk("rst64_busy", 64'(o64_busy), 0);
    chk("rst64_err",  64'(o64_err),  0);
    chk("rst64_fsum", o64_fsum,      0);

    // Table-driven WIDTH=8 runs: clean 3-vector run, then restart from DONE
    // into a 2-vector run whose second vector is wrong.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].do_start) begin
        @(negedge clk);
        s8_valid = 1'b0;
        s8_start = 1'b1;
        s8_nv    = tbl[i].nv;
        @(negedge clk);
        s8_start = 1'b0;
        chk("t8_start_rdy", 64'(o8_rdy), 1);
        chk("t8_start_vec", 64'(o8_vec), 0);
        chk("t8_start_err", 64'(o8_err), 0);
      end
      s8_valid = 1'b1;
      s8_a = tbl[i].a; s8_b = tbl[i].b; s8_sum = tbl[i].sum; s8_cout = tbl[i].cout;
      @(negedge clk);
      chk("t8_vec",  64'(o8_vec),  64'(tbl[i].exp_vec));
      chk("t8_err",  64'(o8_err),  64'(tbl[i].exp_err));
      chk("t8_done", 64'(o8_done), 64'(tbl[i].exp_done));
      chk("t8_pass", 64'(o8_pass), 64'(tbl[i].exp_pass));
      chk("t8_rdy",  64'(o8_rdy),  64'(!tbl[i].exp_done));
    end
    s8_valid = 1'b0;
    chk("t8_fidx",  64'(o8_fidx),  1);
    chk("t8_fsum",  64'(o8_fsum),  64'h93);
    chk("t8_fcout", 64'(o8_fcout), 1);
    s8_valid = 1'b1;
    repeat (3) @(negedge clk);
    s8_valid = 1'b0;
    chk("t8_hold_done", 64'(o8_done), 1);
    chk("t8_hold_vec",  64'(o8_vec),  2);
    chk("t8_hold_err",  64'(o8_err),  1);

    // num_vectors == 0: straight to DONE with pass, in_ready never raised.
    start64(0);
    check64_state("zero");
    final64("zero");
    drv64(1'b1, 64'd5, 64'd6, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_rdy_low", 64'(o64_rdy), 0);
      chk("zero_vec_hold", 64'(o64_vec), 0);
    end
    drv64(1'b0, '0, '0, '0, 1'b0);

    // in_valid pattern 1,0,0,1,0,1 for three vectors.
    run64("gap", 3, 0, 1'b0, 16'h0029, 6, 1'b0);

    // Reset in the middle of a 4-vector run after one good and one bad vector.
    start64(4);
    drv64(1'b1, 64'd1000, 64'd24, 64'd1024, 1'b0);
    model_accept(64'd1000, 64'd24, 64'd1024, 1'b0);
    @(negedge clk);
    drv64(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0);
    model_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0);
    @(negedge clk);
    check64_state("prerst");
    chk("prerst_fidx", 64'(o64_fidx), 1);
    drv64(1'b0, '0, '0, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_rdy",   64'(o64_rdy),   0);
    chk("mrst_busy",  64'(o64_busy),  0);
    chk("mrst_done",  64'(o64_done),  0);
    chk("mrst_pass",  64'(o64_pass),  0);
    chk("mrst_vec",   64'(o64_vec),   0);
    chk("mrst_err",   64'(o64_err),   0);
    chk("mrst_fidx",  64'(o64_fidx),  0);
    chk("mrst_fsum",  o64_fsum,       0);
    chk("mrst_fcout", 64'(o64_fcout), 0);
    run64("fresh", 2, 0, 1'b0, 16'h0, 0, 1'b0);

    // Start pulse during RUN must be ignored.
    run64("midstart", 6, 40, 1'b0, 16'h0, 0, 1'b1);

    // Random runs with injected errors, plus a replay of the last one.
    for (int r = 0; r < 6; r++) begin
      run64("rand", $urandom_range(1, 25), (r % 3) * 30, 1'b0, 16'h0, 0, 1'b0);
    end
    run64("replay", m_nv, 0, 1'b1, 16'h0, 0, 1'b0);

    // Single known vector twice: signature must follow the model both times.
    qa.delete(); qb.delete(); qs.delete(); qc.delete();
    qa.push_back(64'd998); qb.push_back(64'd128); qs.push_back(64'd1126); qc.push_back(1'b0);
    run64("misr1", 1, 0, 1'b1, 16'h0, 0, 1'b0);
    run64("misr2", 1, 0, 1'b1, 16'h0, 0, 1'b0);
    repeat (2) @(negedge clk);
    final64("misr_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
